// File: rtl/steel_tohost_monitor.sv
// Snoops the core data bus for a store to the tohost address and reports the
// test outcome, elapsed RUN cycles and running pass/total counters.
module steel_tohost_monitor #(
   parameter logic [31:0] TOHOST_ADDR    = 32'h00001000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] DATA_OUT,
   input  logic        WR_REQ,
   input  logic [3:0]  WR_MASK,
   output logic [31:0] RESULT,
   output logic [31:0] CYCLE_COUNT,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS,
   output logic        FAIL,
   output logic        TIMEOUT,
   output logic [7:0]  TESTS_RUN,
   output logic [7:0]  TESTS_PASSED
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   logic [1:0]  r_state;
   logic [31:0] r_result;
   logic [31:0] r_cycleCount;
   logic [7:0]  r_testsRun;
   logic [7:0]  r_testsPassed;

   logic        w_hit;
   logic        w_lastCycle;
   logic [31:0] w_hitWord;

   assign w_hit       = WR_REQ && (D_ADDR == TOHOST_ADDR) && (WR_MASK != 4'b0000);
   assign w_lastCycle = (r_cycleCount == TIMEOUT_CYCLES - 32'd1);

   // Only the enabled byte lanes of the store reach RESULT; the rest read as 0.
   assign w_hitWord = {WR_MASK[3] ? DATA_OUT[31:24] : 8'h00,
                       WR_MASK[2] ? DATA_OUT[23:16] : 8'h00,
                       WR_MASK[1] ? DATA_OUT[15:8]  : 8'h00,
                       WR_MASK[0] ? DATA_OUT[7:0]   : 8'h00};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_result      <= 32'd0;
         r_cycleCount  <= 32'd0;
         r_testsRun    <= 8'd0;
         r_testsPassed <= 8'd0;
      end else if (START) begin
         r_state      <= S_RUN;
         r_result     <= 32'd0;
         r_cycleCount <= 32'd0;
      end else if (r_state == S_RUN) begin
         r_cycleCount <= r_cycleCount + 32'd1;
         if (w_hit) begin
            r_result <= w_hitWord;
            r_state  <= S_DONE;
            if (r_testsRun != 8'hFF)
               r_testsRun <= r_testsRun + 8'd1;
            if ((w_hitWord == 32'd1) && (r_testsPassed != 8'hFF))
               r_testsPassed <= r_testsPassed + 8'd1;
         end else if (w_lastCycle) begin
            r_state <= S_TIMEOUT;
            if (r_testsRun != 8'hFF)
               r_testsRun <= r_testsRun + 8'd1;
         end
      end
   end

   assign RESULT       = r_result;
   assign CYCLE_COUNT  = r_cycleCount;
   assign TESTS_RUN    = r_testsRun;
   assign TESTS_PASSED = r_testsPassed;
   assign BUSY         = (r_state == S_RUN);
   assign DONE         = (r_state == S_DONE) || (r_state == S_TIMEOUT);
   assign PASS         = (r_state == S_DONE) && (r_result == 32'd1);
   assign FAIL         = ((r_state == S_DONE) && (r_result != 32'd1)) || (r_state == S_TIMEOUT);
   assign TIMEOUT      = (r_state == S_TIMEOUT);

endmodule

// File: tb/tb_steel_tohost_monitor.sv
// Directed and randomized bench for steel_tohost_monitor against a
// test-level reference model (TIMEOUT_CYCLES = 100).
module tb_steel_tohost_monitor;

   localparam logic [31:0] TOHOST = 32'h00001000;
   localparam int          LIMIT  = 100;

   logic        clock = 1'b0;
   logic        reset, start, wrReq;
   logic [31:0] dAddr, dataOut;
   logic [3:0]  wrMask;
   logic [31:0] result, cycleCount;
   logic        busy, done, pass, failFlag, timeoutFlag;
   logic [7:0]  testsRun, testsPassed;

   int total = 0;
   int bad   = 0;

   typedef enum {M_IDLE, M_RUN, M_DONE, M_TIMEOUT} phase_t;
   phase_t      mPhase;
   logic [31:0] mResult;
   int          mElapsed;
   int          mRun;
   int          mPassed;

   always #5 clock = ~clock;

   steel_tohost_monitor #(
      .TOHOST_ADDR   (TOHOST),
      .TIMEOUT_CYCLES(32'd100)
   ) dut (
      .CLK         (clock),
      .RESET       (reset),
      .START       (start),
      .D_ADDR      (dAddr),
      .DATA_OUT    (dataOut),
      .WR_REQ      (wrReq),
      .WR_MASK     (wrMask),
      .RESULT      (result),
      .CYCLE_COUNT (cycleCount),
      .BUSY        (busy),
      .DONE        (done),
      .PASS        (pass),
      .FAIL        (failFlag),
      .TIMEOUT     (timeoutFlag),
      .TESTS_RUN   (testsRun),
      .TESTS_PASSED(testsPassed)
   );

   // Builds the word a masked store leaves in the result register.
   function automatic logic [31:0] laneMerge(input logic [31:0] data, input logic [3:0] mask);
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < 4; i++)
         if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
      return w;
   endfunction

   // One clock edge of the test-level behaviour: how a test starts, ends and is scored.
   task automatic modelStep(input logic rst, input logic st, input logic [31:0] addr,
                            input logic [31:0] data, input logic wr, input logic [3:0] mask);
      bit isHit;
      isHit = wr && (addr == TOHOST) && (mask != 4'd0);
      if (rst) begin
         mPhase = M_IDLE; mResult = 0; mElapsed = 0; mRun = 0; mPassed = 0;
      end else if (st) begin
         mPhase = M_RUN; mResult = 0; mElapsed = 0;
      end else if (mPhase == M_RUN) begin
         mElapsed++;
         if (isHit) begin
            mPhase  = M_DONE;
            mResult = laneMerge(data, mask);
            mRun    = (mRun + 1 > 255) ? 255 : mRun + 1;
            if (mResult == 1) mPassed = (mPassed + 1 > 255) ? 255 : mPassed + 1;
         end else if (mElapsed == LIMIT) begin
            mPhase = M_TIMEOUT;
            mRun   = (mRun + 1 > 255) ? 255 : mRun + 1;
         end
      end
   endtask

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      checkEq("result", result, mResult);
      checkEq("cycle_count", cycleCount, mElapsed);
      checkEq("busy", {31'd0, busy}, {31'd0, mPhase == M_RUN});
      checkEq("done", {31'd0, done}, {31'd0, mPhase == M_DONE || mPhase == M_TIMEOUT});
      checkEq("pass", {31'd0, pass}, {31'd0, mPhase == M_DONE && mResult == 1});
      checkEq("fail_flag", {31'd0, failFlag},
              {31'd0, (mPhase == M_DONE && mResult != 1) || mPhase == M_TIMEOUT});
      checkEq("timeout_flag", {31'd0, timeoutFlag}, {31'd0, mPhase == M_TIMEOUT});
      checkEq("tests_run", {24'd0, testsRun}, mRun);
      checkEq("tests_passed", {24'd0, testsPassed}, mPassed);
   endtask

   task automatic applyStimulus(input logic rst, input logic st, input logic [31:0] addr,
                                input logic [31:0] data, input logic wr, input logic [3:0] mask);
      reset = rst; start = st; dAddr = addr; dataOut = data; wrReq = wr; wrMask = mask;
      @(posedge clock);
      modelStep(rst, st, addr, data, wr, mask);
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'd0, 32'd0, 0, 4'd0);
   endtask

   initial begin
      logic        rRst, rSt, rWr;
      logic [31:0] rAddr, rData;
      logic [3:0]  rMask;
      int          r;

      reset = 1; start = 0; dAddr = 0; dataOut = 0; wrReq = 0; wrMask = 0;
      mPhase = M_IDLE; mResult = 0; mElapsed = 0; mRun = 0; mPassed = 0;

      // Reset state
      applyStimulus(1, 0, 32'd0, 32'd0, 0, 4'd0);
      applyStimulus(1, 1, TOHOST, 32'd1, 1, 4'hF);
      checkEq("reset_busy", {31'd0, busy}, 32'd0);
      checkEq("reset_result", result, 32'd0);

      // Passing test after 10 idle cycles
      applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
      idleCycles(10);
      applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'hF);
      checkEq("pass_result", result, 32'd1);
      checkEq("pass_flag", {31'd0, pass}, 32'd1);
      checkEq("pass_cycles", cycleCount, 32'd11);
      checkEq("pass_run", {24'd0, testsRun}, 32'd1);
      checkEq("pass_passed", {24'd0, testsPassed}, 32'd1);

      // Masked failing result
      applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
      applyStimulus(0, 0, TOHOST, 32'hDEADBE05, 1, 4'b0001);
      checkEq("masked_result", result, 32'h00000005);
      checkEq("masked_fail", {31'd0, failFlag}, 32'd1);
      checkEq("masked_pass", {31'd0, pass}, 32'd0);

      // Hits and stray writes while DONE are ignored
      applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'hF);
      applyStimulus(0, 0, 32'h00001004, 32'h00000001, 1, 4'hF);
      checkEq("done_hold_result", result, 32'h00000005);

      // Timeout after 100 quiet cycles
      applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
      idleCycles(99);
      checkEq("pre_timeout_busy", {31'd0, busy}, 32'd1);
      idleCycles(1);
      checkEq("timeout_flag_set", {31'd0, timeoutFlag}, 32'd1);
      checkEq("timeout_cycles", cycleCount, 32'd100);

      // Hit on the 100th cycle wins over the timeout
      applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
      idleCycles(99);
      applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'hF);
      checkEq("edge_hit_timeout", {31'd0, timeoutFlag}, 32'd0);
      checkEq("edge_hit_pass", {31'd0, pass}, 32'd1);
      checkEq("edge_hit_cycles", cycleCount, 32'd100);

      // Ignored hits in IDLE and in RUN
      applyStimulus(1, 0, 32'd0, 32'd0, 0, 4'd0);
      applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'hF);
      checkEq("idle_hit_result", result, 32'd0);
      applyStimulus(0, 1, TOHOST, 32'h00000001, 1, 4'hF);
      checkEq("start_hit_busy", {31'd0, busy}, 32'd1);
      checkEq("start_hit_cycles", cycleCount, 32'd0);
      applyStimulus(0, 0, 32'h00001004, 32'h00000001, 1, 4'hF);
      applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'h0);
      applyStimulus(0, 0, TOHOST, 32'h00000001, 0, 4'hF);
      checkEq("nonhit_busy", {31'd0, busy}, 32'd1);

      // Reset mid-test at cycle 50
      applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
      idleCycles(50);
      checkEq("mid_cycles", cycleCount, 32'd50);
      applyStimulus(1, 0, TOHOST, 32'h00000001, 1, 4'hF);
      checkEq("mid_reset_cycles", cycleCount, 32'd0);
      checkEq("mid_reset_busy", {31'd0, busy}, 32'd0);
      checkEq("mid_reset_run", {24'd0, testsRun}, 32'd0);

      // Counter saturation
      for (int i = 0; i < 260; i++) begin
         applyStimulus(0, 1, 32'd0, 32'd0, 0, 4'd0);
         applyStimulus(0, 0, TOHOST, 32'h00000001, 1, 4'hF);
      end
      checkEq("sat_run", {24'd0, testsRun}, 32'd255);
      checkEq("sat_passed", {24'd0, testsPassed}, 32'd255);

      // Randomized traffic against the model
      applyStimulus(1, 0, 32'd0, 32'd0, 0, 4'd0);
      for (int i = 0; i < 3000; i++) begin
         r     = $urandom_range(0, 999);
         rRst  = (r < 2);
         rSt   = (r >= 2 && r < 14);
         rWr   = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0, 1:    rAddr = TOHOST;
            2:       rAddr = 32'h00001004;
            default: rAddr = $urandom;
         endcase
         rData = ($urandom_range(0, 1) == 0) ? 32'h00000001 : $urandom;
         rMask = 4'($urandom_range(0, 15));
         applyStimulus(rRst, rSt, rAddr, rData, rWr, rMask);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
